// File: rtl/rx_module.sv
// UART receiver: 2-flop synchronizer, edge detect, mid-bit sampling, 8N1 frames.
// Define RX_PARITY_EN for 8E1 frames with an even-parity check.
`timescale 1ns/1ps
module rx_module #(
    parameter int BPS_CNT = 5208
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       RX_Pin_In,
    input  logic       RX_En_Sig,
    output logic [7:0] RX_Data,
    output logic       RX_Done_Sig,
    output logic       RX_Err_Sig
);

    localparam logic [15:0] CNT_MAX = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_MID = 16'(BPS_CNT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_nstate;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync3;
    logic [1:0]  r_warm;
    logic        r_arm;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        w_fall;
    logic        w_sample;
    logic        w_cnt_clr;
    logic        w_shift_en;
    logic        w_par_en;
    logic        w_par_ok;
    logic        w_done;
    logic        w_err;

    // Edges only count once the chain holds a real high sample after reset,
    // so a line held low through reset release never looks like a start bit.
    assign w_fall   = r_arm & r_sync3 & ~r_sync2;
    assign w_sample = (r_cnt == CNT_MID);

`ifdef RX_PARITY_EN
    logic r_par;
    assign w_par_ok = (r_par == ^r_shift);
`else
    assign w_par_ok = 1'b1;
`endif

    always_comb begin
        w_nstate   = r_state;
        w_cnt_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_par_en   = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        if (!RX_En_Sig) begin
            w_nstate  = S_IDLE;
            w_cnt_clr = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        w_nstate  = S_START;
                        w_cnt_clr = 1'b1;
                    end
                end
                S_START: begin
                    if (w_sample) w_nstate = r_sync2 ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_sample) begin
                        w_shift_en = 1'b1;
                        if (r_bit == 3'd7) begin
`ifdef RX_PARITY_EN
                            w_nstate = S_PARITY;
`else
                            w_nstate = S_STOP;
`endif
                        end
                    end
                end
`ifdef RX_PARITY_EN
                S_PARITY: begin
                    if (w_sample) begin
                        w_par_en = 1'b1;
                        w_nstate = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_sample) begin
                        w_nstate = S_IDLE;
                        if (r_sync2 && w_par_ok) w_done = 1'b1;
                        else                     w_err  = 1'b1;
                    end
                end
                default: w_nstate = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) r_state <= S_IDLE;
        else       r_state <= w_nstate;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync3     <= 1'b1;
            r_warm      <= 2'd0;
            r_arm       <= 1'b0;
            r_cnt       <= 16'd0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            RX_Data     <= 8'h00;
            RX_Done_Sig <= 1'b0;
            RX_Err_Sig  <= 1'b0;
        end else begin
            r_sync1 <= RX_Pin_In;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
            r_arm <= r_arm | ((r_warm == 2'd2) & r_sync2);
            if (w_cnt_clr || r_state == S_IDLE) r_cnt <= 16'd0;
            else if (r_cnt == CNT_MAX)          r_cnt <= 16'd0;
            else                                r_cnt <= r_cnt + 16'd1;
            if (w_cnt_clr || r_state == S_IDLE) r_bit <= 3'd0;
            else if (w_shift_en)                r_bit <= r_bit + 3'd1;
            if (w_shift_en) r_shift <= {r_sync2, r_shift[7:1]};
            if (w_done) RX_Data <= r_shift;
            RX_Done_Sig <= w_done;
            RX_Err_Sig  <= w_err;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (!RSTn)         r_par <= 1'b0;
        else if (w_par_en) r_par <= r_sync2;
    end
`endif

endmodule
